tpu_compute_core: RTL and testbench

- Compute slice of the tiny TPU: instruction decode (control unit), 2x2 weight-stationary systolic matrix-multiply unit (MMU), and two 2-entry column accumulators.
- Drives a weight-memory address, latches the four weights returned, streams a skewed 2-element activation vector, and collects two column results per accumulator.
- Accumulator contents and full flags feed the unified buffer.

---
 rtl/tpu_compute_core.sv | 161 ++++++++++++++++
 tb/tb_tpu_compute_core.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_compute_core.sv
// Compute slice of the tiny TPU: opcode decode, 2x2 weight-stationary systolic
// array and two 2-entry column accumulators.

module tpu_accumulator #(
    parameter int unsigned ACC_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [ACC_W-1:0] acc_in,
    output logic [ACC_W-1:0] mem_0,
    output logic [ACC_W-1:0] mem_1,
    output logic             full
);
    logic ptr;

    // Fill entry 0 then entry 1; full rises with the entry-1 write and is sticky.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_0 <= '0;
            mem_1 <= '0;
            full  <= 1'b0;
            ptr   <= 1'b0;
        end else if (en && !full) begin
            if (ptr == 1'b0) begin
                mem_0 <= acc_in;
            end else begin
                mem_1 <= acc_in;
                full  <= 1'b1;
            end
            ptr <= ptr + 1'b1;
        end
    end
endmodule

module tpu_compute_core #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instruction,
    input  logic              valid,
    input  logic [DATA_W-1:0] a_in1,
    input  logic [DATA_W-1:0] a_in2,
    output logic [ADDR_W-1:0] weight_addr,
    input  logic [DATA_W-1:0] weight1,
    input  logic [DATA_W-1:0] weight2,
    input  logic [DATA_W-1:0] weight3,
    input  logic [DATA_W-1:0] weight4,
    output logic              load_weight,
    output logic [ACC_W-1:0]  acc_out1,
    output logic [ACC_W-1:0]  acc_out2,
    output logic [ACC_W-1:0]  acc1_mem_0,
    output logic [ACC_W-1:0]  acc1_mem_1,
    output logic [ACC_W-1:0]  acc2_mem_0,
    output logic [ACC_W-1:0]  acc2_mem_1,
    output logic              acc1_full,
    output logic              acc2_full
);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam logic [2:0]  OP_LOAD_WEIGHT = 3'b001;

    logic signed [DATA_W-1:0] w00, w01, w10, w11;
    logic signed [DATA_W-1:0] a00, a10;
    logic signed [DATA_W-1:0] row0_in, row1_in;
    logic signed [ACC_W-1:0]  psum00, psum01, psum10, psum11;
    logic signed [PROD_W-1:0] prod00, prod01, prod10, prod11;
    logic                     valid_d1, valid_d2, valid_d3;

    // Control unit: one-cycle registered decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_weight <= 1'b0;
            weight_addr <= '0;
        end else begin
            load_weight <= (instruction[15:13] == OP_LOAD_WEIGHT);
            weight_addr <= instruction[ADDR_W-1:0];
        end
    end

    // Weight-stationary registers; a load mid-stream takes effect at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w00 <= '0;
            w01 <= '0;
            w10 <= '0;
            w11 <= '0;
        end else if (load_weight) begin
            w00 <= $signed(weight1);
            w01 <= $signed(weight2);
            w10 <= $signed(weight3);
            w11 <= $signed(weight4);
        end
    end

    // Row 1 is qualified one cycle after row 0 to match the caller's skew.
    always_comb begin
        row0_in = valid    ? $signed(a_in1) : '0;
        row1_in = valid_d1 ? $signed(a_in2) : '0;
        prod00  = row0_in * w00;
        prod01  = a00 * w01;
        prod10  = row1_in * w10;
        prod11  = a10 * w11;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_d1 <= 1'b0;
            valid_d2 <= 1'b0;
            valid_d3 <= 1'b0;
        end else begin
            valid_d1 <= valid;
            valid_d2 <= valid_d1;
            valid_d3 <= valid_d2;
        end
    end

    // Systolic PEs: activations flow right, partial sums flow down.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a00    <= '0;
            a10    <= '0;
            psum00 <= '0;
            psum01 <= '0;
            psum10 <= '0;
            psum11 <= '0;
        end else begin
            a00    <= row0_in;
            a10    <= row1_in;
            psum00 <= ACC_W'(prod00);
            psum01 <= ACC_W'(prod01);
            psum10 <= psum00 + ACC_W'(prod10);
            psum11 <= psum01 + ACC_W'(prod11);
        end
    end

    assign acc_out1 = psum10;
    assign acc_out2 = psum11;

    tpu_accumulator #(.ACC_W(ACC_W)) u_acc1 (
        .clk    (clk),
        .reset  (reset),
        .en     (valid_d2),
        .acc_in (acc_out1),
        .mem_0  (acc1_mem_0),
        .mem_1  (acc1_mem_1),
        .full   (acc1_full)
    );

    tpu_accumulator #(.ACC_W(ACC_W)) u_acc2 (
        .clk    (clk),
        .reset  (reset),
        .en     (valid_d3),
        .acc_in (acc_out2),
        .mem_0  (acc2_mem_0),
        .mem_1  (acc2_mem_1),
        .full   (acc2_full)
    );
endmodule

// File: tb/tb_tpu_compute_core.sv
// Directed self-checking bench for tpu_compute_core.

module tb_tpu_compute_core;
    logic        clk;
    logic        reset;
    logic [15:0] instruction;
    logic        valid;
    logic [15:0] a_in1, a_in2;
    logic [12:0] weight_addr;
    logic [15:0] weight1, weight2, weight3, weight4;
    logic        load_weight;
    logic [31:0] acc_out1, acc_out2;
    logic [31:0] acc1_mem_0, acc1_mem_1, acc2_mem_0, acc2_mem_1;
    logic        acc1_full, acc2_full;

    int checks = 0;
    int errors = 0;

    tpu_compute_core dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .valid       (valid),
        .a_in1       (a_in1),
        .a_in2       (a_in2),
        .weight_addr (weight_addr),
        .weight1     (weight1),
        .weight2     (weight2),
        .weight3     (weight3),
        .weight4     (weight4),
        .load_weight (load_weight),
        .acc_out1    (acc_out1),
        .acc_out2    (acc_out2),
        .acc1_mem_0  (acc1_mem_0),
        .acc1_mem_1  (acc1_mem_1),
        .acc2_mem_0  (acc2_mem_0),
        .acc2_mem_1  (acc2_mem_1),
        .acc1_full   (acc1_full),
        .acc2_full   (acc2_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational weight memory model.
    always_comb begin
        case (weight_addr)
            13'd5:   begin weight1 = 16'd1;    weight2 = 16'd2; weight3 = 16'd3;    weight4 = 16'd4; end
            13'd6:   begin weight1 = 16'hFFFF; weight2 = 16'd2; weight3 = 16'hFFFD; weight4 = 16'd4; end
            default: begin weight1 = 16'd100;  weight2 = 16'd100; weight3 = 16'd100; weight4 = 16'd100; end
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        instruction = 16'h0000;
        valid = 1'b0;
        a_in1 = '0;
        a_in2 = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic load_weights(input logic [12:0] addr);
        instruction = {3'b001, addr};
        step();
        instruction = 16'h0000;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (load_weight !== 1'b0 || weight_addr !== 13'd0) begin
            errors++;
            $display("FAIL reset_ctrl: load_weight=%0b weight_addr=%0d, required 0/0", load_weight, weight_addr);
        end
        checks++;
        if (acc_out1 !== 32'd0 || acc_out2 !== 32'd0 || acc1_mem_0 !== 32'd0 || acc2_mem_1 !== 32'd0
            || acc1_full !== 1'b0 || acc2_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: acc_out1=%0h acc_out2=%0h acc1_mem_0=%0h acc2_mem_1=%0h full=%0b%0b, required all 0",
                     acc_out1, acc_out2, acc1_mem_0, acc2_mem_1, acc1_full, acc2_full);
        end
    endtask

    task automatic test_weight_load();
        instruction = 16'h2005;
        step();
        checks++;
        if (load_weight !== 1'b1 || weight_addr !== 13'd5) begin
            errors++;
            $display("FAIL load_decode: load_weight=%0b weight_addr=%0d, required 1/5", load_weight, weight_addr);
        end
        instruction = 16'h0007;
        step();
        checks++;
        if (load_weight !== 1'b0 || weight_addr !== 13'd7) begin
            errors++;
            $display("FAIL nop_decode: load_weight=%0b weight_addr=%0d, required 0/7", load_weight, weight_addr);
        end
        instruction = 16'h0000;
        step();
    endtask

    task automatic test_single_vector();
        valid = 1'b1; a_in1 = 16'd5;
        step();
        valid = 1'b0; a_in1 = 16'd0; a_in2 = 16'd6;
        step();
        a_in2 = 16'd0;
        checks++;
        if (acc_out1 !== 32'd23) begin
            errors++;
            $display("FAIL single_out1: acc_out1=%0d, required 23", $signed(acc_out1));
        end
        step();
        checks++;
        if (acc_out2 !== 32'd34 || acc1_mem_0 !== 32'd23) begin
            errors++;
            $display("FAIL single_out2: acc_out2=%0d acc1_mem_0=%0d, required 34/23", $signed(acc_out2), $signed(acc1_mem_0));
        end
        step();
        checks++;
        if (acc2_mem_0 !== 32'd34 || acc1_full !== 1'b0 || acc2_full !== 1'b0) begin
            errors++;
            $display("FAIL single_acc: acc2_mem_0=%0d full=%0b%0b, required 34/00", $signed(acc2_mem_0), acc1_full, acc2_full);
        end
    endtask

    task automatic test_reset_mid();
        instruction = 16'h2005;
        valid = 1'b1; a_in1 = 16'd9;
        step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (load_weight !== 1'b0 || weight_addr !== 13'd0 || acc1_mem_0 !== 32'd0 || acc2_mem_0 !== 32'd0
            || acc_out1 !== 32'd0 || acc_out2 !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: load_weight=%0b addr=%0d acc1_mem_0=%0d acc2_mem_0=%0d out=%0d/%0d, required all 0",
                     load_weight, weight_addr, acc1_mem_0, acc2_mem_0, acc_out1, acc_out2);
        end
        instruction = 16'h0000;
        valid = 1'b0; a_in1 = 16'd0;
        step();
        reset = 1'b0;
        a_in2 = 16'd7;
        step();
        step();
        step();
        a_in2 = 16'd0;
        checks++;
        if (acc_out1 !== 32'd0 || acc_out2 !== 32'd0 || acc1_mem_0 !== 32'd0 || acc1_full !== 1'b0) begin
            errors++;
            $display("FAIL inflight_discard: acc_out1=%0d acc_out2=%0d acc1_mem_0=%0d full=%0b, required 0",
                     acc_out1, acc_out2, acc1_mem_0, acc1_full);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        load_weights(13'd5);
        valid = 1'b1; a_in1 = 16'd5;
        step();
        a_in1 = 16'd7; a_in2 = 16'd6;
        step();
        valid = 1'b0; a_in1 = 16'd0; a_in2 = 16'd8;
        checks++;
        if (acc_out1 !== 32'd23) begin
            errors++;
            $display("FAIL b2b_out1_first: acc_out1=%0d, required 23", $signed(acc_out1));
        end
        step();
        a_in2 = 16'd0;
        checks++;
        if (acc_out1 !== 32'd31 || acc_out2 !== 32'd34 || acc1_mem_0 !== 32'd23 || acc1_full !== 1'b0) begin
            errors++;
            $display("FAIL b2b_t3: out1=%0d out2=%0d acc1_mem_0=%0d acc1_full=%0b, required 31/34/23/0",
                     $signed(acc_out1), $signed(acc_out2), $signed(acc1_mem_0), acc1_full);
        end
        step();
        checks++;
        if (acc1_mem_1 !== 32'd31 || acc1_full !== 1'b1 || acc_out2 !== 32'd46 || acc2_mem_0 !== 32'd34 || acc2_full !== 1'b0) begin
            errors++;
            $display("FAIL b2b_t4: acc1_mem_1=%0d acc1_full=%0b out2=%0d acc2_mem_0=%0d acc2_full=%0b, required 31/1/46/34/0",
                     $signed(acc1_mem_1), acc1_full, $signed(acc_out2), $signed(acc2_mem_0), acc2_full);
        end
        step();
        checks++;
        if (acc2_mem_1 !== 32'd46 || acc2_full !== 1'b1) begin
            errors++;
            $display("FAIL b2b_t5: acc2_mem_1=%0d acc2_full=%0b, required 46/1", $signed(acc2_mem_1), acc2_full);
        end
    endtask

    task automatic test_overflow_ignore();
        valid = 1'b1; a_in1 = 16'd1;
        step();
        valid = 1'b0; a_in1 = 16'd0; a_in2 = 16'd1;
        step();
        a_in2 = 16'd0;
        checks++;
        if (acc_out1 !== 32'd4) begin
            errors++;
            $display("FAIL ovf_out1: acc_out1=%0d, required 4", $signed(acc_out1));
        end
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (acc1_mem_0 !== 32'd23 || acc1_mem_1 !== 32'd31 || acc2_mem_0 !== 32'd34 || acc2_mem_1 !== 32'd46
            || acc1_full !== 1'b1 || acc2_full !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: acc1=%0d,%0d acc2=%0d,%0d full=%0b%0b, required 23,31 34,46 11",
                     acc1_mem_0, acc1_mem_1, acc2_mem_0, acc2_mem_1, acc1_full, acc2_full);
        end
    endtask

    task automatic test_signed();
        do_reset();
        load_weights(13'd6);
        valid = 1'b1; a_in1 = 16'hFFFB;
        step();
        valid = 1'b0; a_in1 = 16'd0; a_in2 = 16'd6;
        step();
        a_in2 = 16'd0;
        checks++;
        if (acc_out1 !== 32'hFFFF_FFF3) begin
            errors++;
            $display("FAIL signed_out1: acc_out1=%0d, required -13", $signed(acc_out1));
        end
        step();
        checks++;
        if (acc_out2 !== 32'd14 || acc1_mem_0 !== 32'hFFFF_FFF3) begin
            errors++;
            $display("FAIL signed_out2: acc_out2=%0d acc1_mem_0=%0d, required 14/-13", $signed(acc_out2), $signed(acc1_mem_0));
        end
    endtask

    initial begin
        reset = 1'b1;
        instruction = 16'h0000;
        valid = 1'b0;
        a_in1 = '0;
        a_in2 = '0;
        test_reset();
        test_weight_load();
        test_single_vector();
        test_reset_mid();
        test_back_to_back();
        test_overflow_ignore();
        test_signed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
